i2c_cmd_sequencer: RTL

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_cmd_sequencer_if.sv | 38 +++
 rtl/i2c_cmd_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response and I2C-master handshake bundle for i2c_cmd_sequencer.
// The sequencer uses the slave view; the command source / master model uses the master view.
interface i2c_cmd_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [6:0]             cmd_addr;
    logic                   cmd_rw;
    logic [7:0]             cmd_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [7:0]             rsp_data;
    logic [1:0]             rsp_status;
    logic [$clog2(DEPTH):0] pending;
    logic                   m_start;
    logic [6:0]             m_slave_addr;
    logic                   m_rw_bit;
    logic [7:0]             m_tx_data;
    logic                   m_busy;
    logic                   m_done;
    logic                   m_ack_error;
    logic [7:0]             m_rx_data;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_rw, cmd_data, rsp_ready,
        input  m_busy, m_done, m_ack_error, m_rx_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_status, pending,
        output m_start, m_slave_addr, m_rw_bit, m_tx_data
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_rw, cmd_data, rsp_ready,
        output m_busy, m_done, m_ack_error, m_rx_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status, pending,
        input  m_start, m_slave_addr, m_rw_bit, m_tx_data
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C commands, issues them one at a time to a byte-level master,
// retries NACKs a bounded number of times and reports one response per command.
module i2c_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic                clk,
    input logic                rst,
    i2c_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    ST_OK      = 2'b00;
    localparam logic [1:0]    ST_NACK    = 2'b01;
    localparam logic [1:0]    ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [6:0]    r_mem_addr [DEPTH];
    logic          r_mem_rw   [DEPTH];
    logic [7:0]    r_mem_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [RW-1:0] r_retry;
    logic [WW-1:0] r_wdog;
    logic [7:0]    r_rsp_data;
    logic [1:0]    r_rsp_status;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_retry;
    logic [WW-1:0] w_wdog_inc;
    logic          w_wdog_exp;
    logic          w_start;
    logic          w_rsp_valid;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.cmd_valid && !w_full;
    assign w_pop      = (r_state == S_RESP) && bus.rsp_ready;
    assign w_retry    = bus.m_done && bus.m_ack_error && (r_retry < RETRY_MAX);
    assign w_wdog_inc = r_wdog + WW'(1);
    assign w_wdog_exp = (w_wdog_inc == WDOG_LAST);

    // The head entry stays resident until its response is accepted, so it drives the master directly.
    assign bus.cmd_ready    = !w_full;
    assign bus.pending      = r_count;
    assign bus.m_slave_addr = w_empty ? 7'd0 : r_mem_addr[r_rd_ptr];
    assign bus.m_rw_bit     = w_empty ? 1'b0 : r_mem_rw[r_rd_ptr];
    assign bus.m_tx_data    = w_empty ? 8'd0 : r_mem_data[r_rd_ptr];
    assign bus.m_start      = w_start;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_status   = r_rsp_status;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= bus.cmd_addr;
            r_mem_rw[r_wr_ptr]   <= bus.cmd_rw;
            r_mem_data[r_wr_ptr] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty && !bus.m_busy) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.m_done)      w_state_nxt = w_retry ? S_ISSUE : S_RESP;
                else if (w_wdog_exp) w_state_nxt = S_RESP;
            end
            S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_ISSUE: w_start     = 1'b1;
            S_RESP:  w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // m_done takes priority over watchdog expiry; timeouts fall through to RESP without a retry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry      <= '0;
            r_wdog       <= '0;
            r_rsp_data   <= 8'd0;
            r_rsp_status <= ST_OK;
        end else begin
            case (r_state)
                S_ISSUE: r_wdog <= '0;
                S_WAIT: begin
                    if (bus.m_done) begin
                        if (w_retry) begin
                            r_retry <= r_retry + RW'(1);
                        end else begin
                            r_rsp_status <= bus.m_ack_error ? ST_NACK : ST_OK;
                            r_rsp_data   <= (!bus.m_ack_error && r_mem_rw[r_rd_ptr]) ? bus.m_rx_data : 8'd0;
                        end
                    end else if (w_wdog_exp) begin
                        r_rsp_status <= ST_TIMEOUT;
                        r_rsp_data   <= 8'd0;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_retry      <= '0;
                        r_rsp_data   <= 8'd0;
                        r_rsp_status <= ST_OK;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
